// File: rtl/spi_block_engine.sv
// Sector-transfer engine in front of the SPI byte shifter: forwards single CPU accesses,
// or moves a whole BUF_BYTES block between an internal buffer and the card on its own.
module spi_block_engine #(
  parameter int         BUF_BYTES = 512,
  parameter logic [7:0] TX_FILL   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  input  logic        cpu_iordin,
  output logic        cpu_iordout,
  input  logic        cpu_iowrin,
  output logic        cpu_iowrout,
  output logic        ready,
  output logic [11:0] spi_addr,
  output logic [15:0] spi_wdata,
  output logic        spi_iowr,
  input  logic        spi_iowr_ack,
  input  logic [7:0]  spi_rdata,
  input  logic        spi_ready
);
  localparam int PTR_W = $clog2(BUF_BYTES);

  localparam logic [11:0] A_CTRL = 12'h0B0;
  localparam logic [11:0] A_PRE  = 12'h0B1;
  localparam logic [11:0] A_DATA = 12'h0B2;
  localparam logic [11:0] A_CMD  = 12'h0B4;
  localparam logic [11:0] A_STAT = 12'h0B5;
  localparam logic [11:0] A_BUF  = 12'h0B6;
  localparam logic [11:0] A_PTR  = 12'h0B7;

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_ISSUE, S_ACK, S_SHIFT, S_NEXT} state_t;
  // FWD_NS: forwarded 0B0/0B1 (no shift follows); FWD_SH: forwarded 0B2
  typedef enum logic [1:0] {M_FWD_NS, M_FWD_SH, M_BRD, M_BWR} mode_t;

  state_t            state, state_nxt;
  mode_t             mode;
  logic [PTR_W-1:0]  ptr, idx;
  logic              done;
  logic [7:0]        last_rx, rdata, wr_byte;
  logic [11:0]       fwd_addr;
  logic [15:0]       fwd_data, wdata_q;
  logic [7:0]        buf_mem [BUF_BYTES];

  logic rd_req, wr_req, idle, busy, fwd_hit, cmd_hit, blk, last_byte, ack_ok;
  logic cpu_we, eng_we, ptr_inc, ptr_ld;

  assign rd_req    = cpu_iordin != cpu_iordout;
  assign wr_req    = cpu_iowrin != cpu_iowrout;
  assign idle      = state == S_IDLE;
  assign busy      = !idle;
  assign ack_ok    = spi_iowr_ack == spi_iowr;
  assign blk       = mode == M_BRD || mode == M_BWR;
  assign last_byte = idx == PTR_W'(BUF_BYTES - 1);

  assign fwd_hit = wr_req && idle &&
                   (cpu_addr == A_CTRL || cpu_addr == A_PRE || cpu_addr == A_DATA);
  assign cmd_hit = wr_req && idle && cpu_addr == A_CMD && (cpu_din[0] ^ cpu_din[1]);

  assign cpu_we  = wr_req && idle && cpu_addr == A_BUF;
  assign eng_we  = state == S_NEXT && mode == M_BRD;
  assign ptr_inc = idle && ((rd_req && cpu_addr == A_BUF) || cpu_we);
  assign ptr_ld  = idle && wr_req && cpu_addr == A_PTR;

  assign ready     = idle && spi_ready;
  assign spi_wdata = (mode == M_BWR) ? {8'h00, wr_byte} : wdata_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_SYNC:  if (ack_ok) state_nxt = S_IDLE;
      S_IDLE:  if (fwd_hit || cmd_hit) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_ACK;
      S_ACK:   if (ack_ok) state_nxt = (mode == M_FWD_NS) ? S_IDLE : S_SHIFT;
      S_SHIFT: if (spi_ready) state_nxt = blk ? S_NEXT : S_IDLE;
      S_NEXT:  state_nxt = last_byte ? S_IDLE : S_ISSUE;
      default: state_nxt = S_SYNC;
    endcase
  end

  always_comb begin
    cpu_dout = 16'h0000;
    case (cpu_addr)
      A_DATA:  cpu_dout = {8'h00, last_rx};
      A_STAT:  cpu_dout = {4'b0000, 9'(idx), spi_ready, done, busy};
      A_BUF:   cpu_dout = {8'h00, rdata};
      default: cpu_dout = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_SYNC;
      mode        <= M_FWD_NS;
      ptr         <= '0;
      idx         <= '0;
      done        <= 1'b0;
      last_rx     <= 8'h00;
      fwd_addr    <= 12'h000;
      fwd_data    <= 16'h0000;
      spi_addr    <= 12'h000;
      wdata_q     <= 16'h0000;
      spi_iowr    <= 1'b0;
      cpu_iordout <= 1'b0;
      cpu_iowrout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cpu_iordout <= cpu_iordin;
      cpu_iowrout <= cpu_iowrin;

      if (fwd_hit) begin
        mode     <= (cpu_addr == A_DATA) ? M_FWD_SH : M_FWD_NS;
        fwd_addr <= cpu_addr;
        fwd_data <= cpu_din;
      end else if (cmd_hit) begin
        mode <= cpu_din[0] ? M_BRD : M_BWR;
      end

      if (state == S_ISSUE) begin
        spi_addr <= blk ? A_DATA : fwd_addr;
        wdata_q  <= (mode == M_BRD) ? {8'h00, TX_FILL} : fwd_data;
        spi_iowr <= ~spi_iowr;
      end

      if (state == S_SHIFT && spi_ready) last_rx <= spi_rdata;

      if (state == S_NEXT) idx <= last_byte ? '0 : idx + 1'b1;

      // a completing block wins over a same-cycle status read
      if (state == S_NEXT && last_byte)      done <= 1'b1;
      else if (cmd_hit)                      done <= 1'b0;
      else if (rd_req && cpu_addr == A_STAT) done <= 1'b0;

      if (ptr_ld)       ptr <= cpu_din[PTR_W-1:0];
      else if (ptr_inc) ptr <= ptr + 1'b1;
    end
  end

  // Buffer: CPU read port, engine read port feeding block writes, one write port
  always_ff @(posedge clk) begin
    if (eng_we)      buf_mem[idx] <= last_rx;
    else if (cpu_we) buf_mem[ptr] <= cpu_din[7:0];
    rdata <= buf_mem[ptr];
    if (state == S_ISSUE) wr_byte <= buf_mem[idx];
  end

endmodule

// File: tb/tb_spi_block_engine.sv
// Directed bench for spi_block_engine with a behavioural SPI shifter that acks, shifts
// for a few cycles and logs every byte it receives.
module tb_spi_block_engine;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] cpu_addr = 12'h000;
  logic [15:0] cpu_din = 16'h0000;
  logic [15:0] cpu_dout;
  logic        cpu_iordin = 1'b0, cpu_iordout;
  logic        cpu_iowrin = 1'b0, cpu_iowrout;
  logic        ready;
  logic [11:0] spi_addr;
  logic [15:0] spi_wdata;
  logic        spi_iowr;
  logic        spi_iowr_ack = 1'b0;
  logic [7:0]  spi_rdata = 8'h00;
  logic        spi_ready = 1'b1;

  int vecs = 0, errs = 0;

  spi_block_engine dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .cpu_iordin(cpu_iordin), .cpu_iordout(cpu_iordout),
    .cpu_iowrin(cpu_iowrin), .cpu_iowrout(cpu_iowrout),
    .ready(ready),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_iowr(spi_iowr),
    .spi_iowr_ack(spi_iowr_ack), .spi_rdata(spi_rdata), .spi_ready(spi_ready)
  );

  always #5 clk = ~clk;

  // Shifter model: nth 0B2 transfer since 'base' returns n&FF; acks stall once freeze_at reached
  int         xfer_cnt = 0, tog_cnt = 0, base = 0, shift_cnt = 0, freeze_at = -1;
  logic [11:0] last_addr = 12'h000;
  logic [15:0] last_wdata = 16'h0000;
  logic [7:0]  wlog [0:1023];

  always @(posedge clk) begin
    if (shift_cnt > 0) begin
      shift_cnt <= shift_cnt - 1;
      if (shift_cnt == 1) spi_ready <= 1'b1;
    end else if (spi_iowr != spi_iowr_ack &&
                 !(freeze_at >= 0 && (xfer_cnt - base) >= freeze_at)) begin
      spi_iowr_ack <= spi_iowr;
      tog_cnt      <= tog_cnt + 1;
      last_addr    <= spi_addr;
      last_wdata   <= spi_wdata;
      if (spi_addr == 12'h0B2) begin
        wlog[(xfer_cnt - base) & 1023] <= spi_wdata[7:0];
        spi_rdata <= 8'(xfer_cnt - base);
        spi_ready <= 1'b0;
        shift_cnt <= 3;
        xfer_cnt  <= xfer_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    cpu_addr   = a;
    cpu_din    = d;
    cpu_iowrin = ~cpu_iowrin;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic rd(input logic [11:0] a, output logic [15:0] d);
    @(negedge clk);
    cpu_addr   = a;
    cpu_iordin = ~cpu_iordin;
    #1 d = cpu_dout;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic wait_ready(input int lim, input string tag);
    int n = 0;
    @(negedge clk);
    while (!ready && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {15'b0, ready}, 16'h0001);
  endtask

  initial begin
    logic [15:0] d;
    int t0, bad, n;

    // 1: reset
    #1;
    chk("rst_ready", {15'b0, ready}, 16'h0000);
    chk("rst_spi", {3'b0, spi_iowr, spi_addr}, 16'h0000);
    chk("rst_wdata", spi_wdata, 16'h0000);
    chk("rst_acks", {14'b0, cpu_iordout, cpu_iowrout}, 16'h0000);
    chk("rst_dout", cpu_dout, 16'h0000);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("sync_to_idle", {15'b0, ready}, 16'h0001);
    rd(12'h0B5, d);
    chk("stat_reset", d, 16'h0004);

    // 2: forwarding
    t0 = tog_cnt;
    wr(12'h0B1, 16'h0300);
    wait_ready(50, "fwd_b1_ready");
    chk("fwd_b1_toggles", 16'(tog_cnt - t0), 16'd1);
    chk("fwd_b1_addr", {4'b0, last_addr}, 16'h00B1);
    chk("fwd_b1_data", last_wdata, 16'h0300);
    base = xfer_cnt - 60;
    wr(12'h0B2, 16'h00A5);
    wait_ready(50, "fwd_b2_ready");
    chk("fwd_b2_data", last_wdata, 16'h00A5);
    rd(12'h0B2, d);
    chk("fwd_b2_last_rx", d, 16'h003C);

    // 3: block read
    base = xfer_cnt;
    t0 = tog_cnt;
    wr(12'h0B4, 16'h0001);
    wait_ready(20000, "brd_ready");
    chk("brd_toggles", 16'(tog_cnt - t0), 16'd512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (wlog[i] !== 8'hFF) bad++;
    chk("brd_fill_bad", 16'(bad), 16'd0);
    rd(12'h0B5, d);
    chk("brd_stat_done", d, 16'h0006);
    wr(12'h0B7, 16'h0000);
    for (int i = 0; i < 512; i++) begin
      rd(12'h0B6, d);
      chk("brd_buf", d, 16'(i & 255));
    end

    // 4: block write
    wr(12'h0B7, 16'h0000);
    for (int i = 0; i < 512; i++) wr(12'h0B6, 16'((i * 3) & 255));
    base = xfer_cnt;
    t0 = tog_cnt;
    wr(12'h0B4, 16'h0002);
    wait_ready(20000, "bwr_ready");
    chk("bwr_toggles", 16'(tog_cnt - t0), 16'd512);
    bad = 0;
    for (int i = 0; i < 512; i++) if (wlog[i] !== 8'((i * 3) & 255)) bad++;
    chk("bwr_seq_bad", 16'(bad), 16'd0);
    rd(12'h0B5, d);
    chk("bwr_stat_done", d, 16'h0006);
    rd(12'h0B5, d);
    chk("bwr_stat_clr", d, 16'h0004);

    // 5: accesses while busy are dropped; cmd 3 is a no-op
    wr(12'h0B7, 16'h0005);
    base = xfer_cnt;
    t0 = tog_cnt;
    wr(12'h0B4, 16'h0001);
    wr(12'h0B4, 16'h0001);
    wr(12'h0B0, 16'h0001);
    wr(12'h0B6, 16'h0077);
    wr(12'h0B7, 16'h01FF);
    rd(12'h0B5, d);
    chk("busy_bit", {15'b0, d[0]}, 16'h0001);
    wait_ready(20000, "busy_blk_ready");
    chk("busy_toggles", 16'(tog_cnt - t0), 16'd512);
    @(negedge clk);
    rd(12'h0B6, d);
    chk("busy_buf5", d, 16'h0005);
    rd(12'h0B6, d);
    chk("busy_buf6", d, 16'h0006);
    t0 = tog_cnt;
    wr(12'h0B4, 16'h0003);
    @(negedge clk);
    chk("cmd3_ready", {15'b0, ready}, 16'h0001);
    chk("cmd3_toggles", 16'(tog_cnt - t0), 16'd0);
    rd(12'h0B5, d);
    chk("cmd3_done_kept", d, 16'h0006);
    rd(12'h0B5, d);
    chk("cmd3_done_clr", d, 16'h0004);

    // 6: reset mid-block with an ack pending
    wr(12'h0B0, 16'h0000);
    wait_ready(50, "pre6_ready");
    base = xfer_cnt;
    freeze_at = 100;
    wr(12'h0B4, 16'h0001);
    n = 0;
    while (!((xfer_cnt - base) == 100 && spi_iowr != spi_iowr_ack) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("freeze_reached", 16'(xfer_cnt - base), 16'd100);
    repeat (3) @(negedge clk);
    rd(12'h0B5, d);
    chk("freeze_stat", d, 16'h0325);
    @(negedge clk);
    reset_n    = 1'b0;
    cpu_iordin = 1'b0;
    cpu_iowrin = 1'b0;
    @(negedge clk);
    chk("rst2_spi_iowr", {15'b0, spi_iowr}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("sync_hold", {15'b0, ready}, 16'h0000);
    freeze_at = -1;
    wait_ready(50, "sync_release");
    base = xfer_cnt;
    wr(12'h0B4, 16'h0001);
    wait_ready(20000, "rd2_ready");
    rd(12'h0B5, d);
    chk("rd2_stat", d, 16'h0006);
    wr(12'h0B7, 16'h01FF);
    rd(12'h0B6, d);
    chk("rd2_buf511", d, 16'h00FF);
    rd(12'h0B6, d);
    chk("rd2_buf0_wrap", d, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
